// File: rtl/ring_rr_arbiter_pkg.sv
// Shared definitions for the 6-way ring round-robin arbiter: FSM encoding,
// pointer reset value and one-hot ring helpers.
package ring_rr_arbiter_pkg;

  localparam int unsigned NumReq = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StGap   = 2'b10
  } arb_state_e;

  localparam logic [NumReq-1:0] PtrReset = 6'b100000;

  // One-hot rotate right with wrap: bit0 -> bit5.
  function automatic logic [NumReq-1:0] ring_rot6(input logic [NumReq-1:0] x);
    return {x[0], x[NumReq-1:1]};
  endfunction

  function automatic logic is_onehot6(input logic [NumReq-1:0] x);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < NumReq; i++) begin
      if (x[i]) cnt++;
    end
    return cnt == 1;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_pick.sv
// Combinational ring search: first set req bit starting at ptr and walking
// toward lower indices, wrapping bit0 -> bit5. Output is one-hot or zero.
module rr_pick6
  import ring_rr_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] ptr,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] pick
);

  int   start;
  int   idx;
  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    start = 0;
    idx   = 0;
    for (int i = 0; i < NumReq; i++) begin
      if (ptr[i]) start = i;
    end
    for (int k = 0; k < NumReq; k++) begin
      idx = start - k;
      if (idx < 0) idx = idx + NumReq;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// 6-requester round-robin arbiter with bounded hold time and a one-cycle
// turnaround gap between owners.
module ring_rr_arbiter
  import ring_rr_arbiter_pkg::*;
#(
  parameter int unsigned N        = 6,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic [N-1:0] ptr,
  output logic         timeout
);

  localparam int unsigned      HoldW   = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     pick;

  logic corrupt;
  logic rel_done, rel_drop, rel_max;

  rr_pick6 u_pick (
    .ptr  (ptr_q),
    .req  (req),
    .pick (pick)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;

    rel_done = done;
    rel_drop = (req & gnt_q) == '0;
    rel_max  = hold_cnt_q == HoldMax;

    // Upset state or pointer: fall back to the reset condition.
    corrupt = !is_onehot6(ptr_q) ||
              !(state_q inside {StIdle, StGrant, StGap});

    if (corrupt) begin
      state_d    = StIdle;
      gnt_d      = '0;
      ptr_d      = PtrReset;
      busy_d     = 1'b0;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        StGrant: begin
          if (rel_done || rel_drop || rel_max) begin
            state_d    = StGap;
            gnt_d      = '0;
            busy_d     = 1'b0;
            ptr_d      = ring_rot6(gnt_q);
            hold_cnt_d = '0;
            timeout_d  = rel_max && !rel_done && !rel_drop;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: begin
          // Idle and Gap share the same arbitration step.
          if (req != '0) begin
            state_d    = StGrant;
            gnt_d      = pick;
            busy_d     = 1'b1;
            hold_cnt_d = HoldW'(1);
          end else begin
            state_d    = StIdle;
            gnt_d      = '0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      ptr_q      <= PtrReset;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign ptr     = ptr_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter: an index-level reference model is
// compared on every falling edge, plus hand-computed literal checks.
module tb_ring_rr_arbiter;

  localparam int MaxHold = 8;

  logic       clk;
  logic       rstb;
  logic [5:0] req;
  logic       done;
  logic [5:0] gnt;
  logic       busy;
  logic [5:0] ptr;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  ring_rr_arbiter #(
    .N        (6),
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .busy    (busy),
    .ptr     (ptr),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner and pointer as ring indices (5 = top of ring).
  int m_owner = -1;
  int m_ptr   = 5;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  function automatic int pick_idx(input logic [5:0] r, input int p);
    for (int k = 0; k < 6; k++) begin
      int i;
      i = (p - k + 6) % 6;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rstb) begin : model
    int p;
    if (!rstb) begin
      m_owner <= -1;
      m_ptr   <= 5;
      m_hold  <= 0;
      m_to    <= 1'b0;
    end else if (m_owner >= 0) begin
      if (done || !req[m_owner] || m_hold == MaxHold) begin
        m_to    <= (m_hold == MaxHold) && !done && req[m_owner];
        m_ptr   <= (m_owner + 5) % 6;
        m_owner <= -1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end else begin
      m_to <= 1'b0;
      p = pick_idx(req, m_ptr);
      if (p >= 0) begin
        m_owner <= p;
        m_hold  <= 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [5:0] eg;
    logic [5:0] ep;
    eg = '0;
    ep = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    ep[m_ptr] = 1'b1;
    chk("model_gnt", gnt, eg);
    chk("model_ptr", ptr, ep);
    chk("model_busy", {5'b0, busy}, {5'b0, m_owner >= 0});
    chk("model_timeout", {5'b0, timeout}, {5'b0, m_to});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] exp;
    rstb = 1'b1;
    req  = '0;
    done = 1'b0;
    #2 rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;

    // 1: idle with no requests
    repeat (10) tick();
    chk("t1_gnt", gnt, 6'b000000);
    chk("t1_ptr", ptr, 6'b100000);
    chk("t1_busy", {5'b0, busy}, 6'b000000);

    // 2: two requesters, done on third grant cycle
    req = 6'b100001;
    tick();
    chk("t2_gnt_c1", gnt, 6'b100000);
    tick();
    tick();
    chk("t2_gnt_c3", gnt, 6'b100000);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t2_gap_gnt", gnt, 6'b000000);
    chk("t2_gap_ptr", ptr, 6'b010000);
    tick();
    chk("t2_gnt_second", gnt, 6'b000001);
    req = '0;
    tick();
    tick();

    // 3: hold-time limit
    req = 6'b000100;
    tick();
    chk("t3_gnt_c1", gnt, 6'b000100);
    repeat (7) tick();
    chk("t3_gnt_c8", gnt, 6'b000100);
    tick();
    chk("t3_gap_gnt", gnt, 6'b000000);
    chk("t3_timeout", {5'b0, timeout}, 6'b000001);
    chk("t3_ptr", ptr, 6'b000010);
    tick();
    chk("t3_regrant", gnt, 6'b000100);
    chk("t3_timeout_clr", {5'b0, timeout}, 6'b000000);
    req = '0;
    tick();
    tick();

    // 4: drop and done together
    req = 6'b000010;
    tick();
    chk("t4_gnt", gnt, 6'b000010);
    tick();
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4_gnt_rel", gnt, 6'b000000);
    chk("t4_timeout", {5'b0, timeout}, 6'b000000);
    chk("t4_ptr", ptr, 6'b000001);
    tick();

    // 5: full rotation from reset pointer
    rstb = 1'b0;
    #3 rstb = 1'b1;
    tick();
    req  = 6'b111111;
    done = 1'b1;
    for (int g = 0; g < 7; g++) begin
      exp = 6'b100000 >> (g % 6);
      tick();
      chk("t5_gnt", gnt, exp);
      tick();
      chk("t5_gap", gnt, 6'b000000);
    end
    req  = '0;
    done = 1'b0;
    tick();

    // 6: asynchronous reset mid-grant
    req = 6'b000100;
    tick();
    chk("t6_gnt", gnt, 6'b000100);
    tick();
    @(negedge clk);
    #1 rstb = 1'b0;
    #1;
    chk("t6_async_gnt", gnt, 6'b000000);
    chk("t6_async_ptr", ptr, 6'b100000);
    chk("t6_async_busy", {5'b0, busy}, 6'b000000);
    tick();
    chk("t6_held_gnt", gnt, 6'b000000);
    req  = '0;
    rstb = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
